// File: rtl/req_dispatch_pkg.sv
// rtl/req_dispatch_pkg.sv - floor type and controller command packing helper
`include "global.vh"

package req_dispatch_pkg;

    typedef logic [7:0] floor_t;

    function automatic logic [2:0] pack_req(input logic up, input logic down, input logic open);
        logic [2:0] r;
        r            = '0;
        r[`REQ_UP]   = up;
        r[`REQ_DOWN] = down;
        r[`REQ_OPEN] = open;
        return r;
    endfunction

endpackage

// File: rtl/global.vh
// rtl/global.vh - shared floor count, controller state codes and req bit positions
`ifndef GLOBAL_VH
`define GLOBAL_VH

`define F_N      8

`define RS_UP    4'h1
`define RS_DOWN  4'h2

`define DS_OPEN  4'h1
`define DS_CLOSE 4'h2

`define REQ_UP   2
`define REQ_DOWN 1
`define REQ_OPEN 0

`endif

// File: rtl/req_dispatch_btn_edge.sv
// rtl/req_dispatch_btn_edge.sv - btn_edge: per-bit 2-flop synchroniser and rising-edge detector
module btn_edge #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] btn_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] sync1_q;
    logic [W-1:0] sync2_q;
    logic [W-1:0] prev_q;
    logic [W-1:0] armed_q;
    logic [1:0]   flush_q;

    // A bit is armed only once its synchronised level has been seen low after
    // reset, so a button held through reset never counts as a fresh press.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            armed_q <= '0;
            flush_q <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            flush_q <= {flush_q[0], 1'b1};
            if (flush_q[1]) begin
                armed_q <= armed_q | ~sync2_q;
            end
        end
    end

    assign rise_o = sync2_q & ~prev_q & armed_q;

endmodule

// File: rtl/req_dispatch.sv
// rtl/req_dispatch.sv - floor call latching and up/down/open request generation
// Optional toggle-cancel of a pending call enabled by defining REQ_CANCEL_EN.
`include "global.vh"

module req_dispatch
    import req_dispatch_pkg::*;
#(
    parameter int F_N = `F_N
) (
    input  logic           clk10hz,
    input  logic           rst_n,
    input  logic [F_N-1:0] floor_btn,
    input  floor_t         curr_floor,
    input  logic [3:0]     door_state,
    input  logic [3:0]     running_state,
    output logic [2:0]     req,
    output logic [F_N-1:0] pending
);

    logic [F_N-1:0] press;
    logic [F_N-1:0] pending_q, pending_d;
    logic [2:0]     req_q, req_d;
    logic [F_N-1:0] here_vec;
    logic [F_N-1:0] clear_vec;
    logic           above, below, here;
    logic           door_open, door_close;
    logic           unused_running;

    // Direction arbitration belongs to the controller; running_state is not used here.
    assign unused_running = ^running_state;

    btn_edge #(.W(F_N)) u_btn_edge (
        .clk_i  (clk10hz),
        .rst_ni (rst_n),
        .btn_i  (floor_btn),
        .rise_o (press)
    );

    assign door_open  = (door_state == `DS_OPEN);
    assign door_close = (door_state == `DS_CLOSE);

    // Out-of-range floors match no index, so here/clear vanish and every call reads as below.
    always_comb begin
        here_vec = '0;
        above    = 1'b0;
        below    = 1'b0;
        for (int j = 0; j < F_N; j++) begin
            here_vec[j] = (8'(j) == curr_floor);
            above       = above | (pending_q[j] & (8'(j) > curr_floor));
            below       = below | (pending_q[j] & (8'(j) < curr_floor));
        end
    end

    assign here      = |(pending_q & here_vec);
    assign clear_vec = here_vec & {F_N{door_open}};

`ifdef REQ_CANCEL_EN
    logic [F_N-1:0] cancel_vec;
    assign cancel_vec = press & pending_q & ~here_vec;
    assign pending_d  = (pending_q | press) & ~cancel_vec & ~clear_vec;
`else
    assign pending_d  = (pending_q | press) & ~clear_vec;
`endif

    assign req_d = pack_req(above, below, here & door_close);

    always_ff @(posedge clk10hz or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            req_q     <= '0;
        end else begin
            pending_q <= pending_d;
            req_q     <= req_d;
        end
    end

    assign pending = pending_q;
    assign req     = req_q;

endmodule

// File: tb/tb_req_dispatch.sv
// tb/tb_req_dispatch.sv - directed self-checking bench for req_dispatch at F_N = 8
module tb_req_dispatch;

    localparam logic [3:0] DS_OPEN  = 4'h1;
    localparam logic [3:0] DS_CLOSE = 4'h2;
    localparam logic [3:0] RS_UP    = 4'h1;

    logic       clk10hz = 1'b0;
    logic       rst_n;
    logic [7:0] floor_btn;
    logic [7:0] curr_floor;
    logic [3:0] door_state;
    logic [3:0] running_state;
    logic [2:0] req;
    logic [7:0] pending;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk10hz = ~clk10hz;

    req_dispatch #(.F_N(8)) dut (
        .clk10hz       (clk10hz),
        .rst_n         (rst_n),
        .floor_btn     (floor_btn),
        .curr_floor    (curr_floor),
        .door_state    (door_state),
        .running_state (running_state),
        .req           (req),
        .pending       (pending)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk10hz);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        floor_btn     = '0;
        curr_floor    = 8'd0;
        door_state    = DS_CLOSE;
        running_state = RS_UP;
        #2;
        check("reset_pending", pending, 8'h00);
        check("reset_req", {5'd0, req}, 8'h00);

        tick(1);
        rst_n = 1'b1;
        tick(5);

        // Press floor 5 at floor 0: set after 3 edges, req after 4
        floor_btn[5] = 1'b1;
        tick(3);
        check("p5_pending", pending, 8'b0010_0000);
        check("p5_req_not_early", {5'd0, req}, 8'h00);
        tick(1);
        check("p5_req_up", {5'd0, req}, 8'b0000_0100);
        floor_btn[5] = 1'b0;
        tick(3);

        // Arrive at floor 5 with door closed, then open
        curr_floor = 8'd5;
        tick(1);
        check("f5_open_req", {5'd0, req}, 8'b0000_0001);
        door_state = DS_OPEN;
        tick(1);
        check("f5_cleared", pending, 8'h00);
        tick(1);
        check("f5_req_idle", {5'd0, req}, 8'h00);

        // Calls on 1 and 6 from floor 3
        door_state = DS_CLOSE;
        curr_floor = 8'd3;
        floor_btn  = 8'b0100_0010;
        tick(3);
        check("f1f6_pending", pending, 8'b0100_0010);
        tick(1);
        check("f1f6_req_both", {5'd0, req}, 8'b0000_0110);
        floor_btn  = '0;
        curr_floor = 8'd6;
        door_state = DS_OPEN;
        tick(1);
        check("f6_served", pending, 8'b0000_0010);
        tick(1);
        check("f6_req_down", {5'd0, req}, 8'b0000_0010);
        curr_floor = 8'd1;
        tick(1);
        check("f1_served", pending, 8'h00);
        tick(1);
        check("no_calls_req", {5'd0, req}, 8'h00);

        // Held button sets once; press during open door at same floor is swallowed
        door_state   = DS_CLOSE;
        curr_floor   = 8'd0;
        floor_btn[2] = 1'b1;
        tick(20);
        check("hold_pending", pending, 8'b0000_0100);
        check("hold_req", {5'd0, req}, 8'b0000_0100);
        floor_btn[2] = 1'b0;
        curr_floor   = 8'd2;
        door_state   = DS_OPEN;
        tick(1);
        check("f2_served", pending, 8'h00);
        tick(3);
        floor_btn[2] = 1'b1;
        tick(3);
        check("f2_press_open_door", pending, 8'h00);
        tick(2);
        check("f2_still_clear", pending, 8'h00);
        floor_btn[2] = 1'b0;
        tick(3);

        // Out-of-range floor: everything counts as below, nothing cleared
        curr_floor   = 8'd0;
        door_state   = DS_CLOSE;
        floor_btn[3] = 1'b1;
        tick(3);
        check("f3_pending", pending, 8'b0000_1000);
        floor_btn[3] = 1'b0;
        curr_floor   = 8'd9;
        door_state   = DS_OPEN;
        tick(1);
        check("oor_no_clear", pending, 8'b0000_1000);
        tick(1);
        check("oor_req_down", {5'd0, req}, 8'b0000_0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pending", pending, 8'h00);
        check("async_rst_req", {5'd0, req}, 8'h00);

        // Button held through reset must not register until re-pressed
        curr_floor   = 8'd0;
        door_state   = DS_CLOSE;
        floor_btn[1] = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(8);
        check("held_thru_reset", pending, 8'h00);
        floor_btn[1] = 1'b0;
        tick(4);
        floor_btn[1] = 1'b1;
        tick(3);
        check("repress_after_reset", pending, 8'b0000_0010);
        floor_btn[1] = 1'b0;
        curr_floor   = 8'd1;
        door_state   = DS_OPEN;
        tick(1);
        check("f1_served_again", pending, 8'h00);
        tick(3);

        // Second press on a pending floor
        curr_floor   = 8'd0;
        door_state   = DS_CLOSE;
        floor_btn[4] = 1'b1;
        tick(3);
        check("f4_first", pending, 8'b0001_0000);
        floor_btn[4] = 1'b0;
        tick(3);
        floor_btn[4] = 1'b1;
        tick(3);
`ifdef REQ_CANCEL_EN
        check("f4_second", pending, 8'h00);
        tick(1);
        check("f4_req", {5'd0, req}, 8'h00);
`else
        check("f4_second", pending, 8'b0001_0000);
        tick(1);
        check("f4_req", {5'd0, req}, 8'b0000_0100);
`endif
        floor_btn[4] = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
